// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back register file slice: widths, enable levels,
// the NOP register address and the stall-vector bit positions.
package wb_regfile_pkg;
    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NREG   = 32;

    localparam logic [RF_DATA_W-1:0] ZeroWord   = '0;
    localparam logic [RF_ADDR_W-1:0] NOPRegAddr = '0;

    localparam logic RstEnable    = 1'b1;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;

    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;
endpackage

// File: rtl/wb_regfile_result_latch.sv
// One pipeline latch for a (wd, wreg, wdata) result. It inserts a bubble when its
// own stage stalls but the next stage does not, holds when both stall, and captures otherwise.
module result_latch
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_self,
    input  logic              stall_next,
    input  logic [ADDR_W-1:0] src_wd,
    input  logic              src_wreg,
    input  logic [DATA_W-1:0] src_wdata,
    output logic [ADDR_W-1:0] wd,
    output logic              wreg,
    output logic [DATA_W-1:0] wdata
);
    logic [ADDR_W-1:0] wd_reg;
    logic              wreg_reg;
    logic [DATA_W-1:0] wdata_reg;

    always_ff @(posedge clk) begin
        if (rst == RstEnable || (stall_self && !stall_next)) begin
            wd_reg    <= ADDR_W'(NOPRegAddr);
            wreg_reg  <= WriteDisable;
            wdata_reg <= DATA_W'(ZeroWord);
        end else if (!stall_self) begin
            wd_reg    <= src_wd;
            wreg_reg  <= src_wreg;
            wdata_reg <= src_wdata;
        end
    end

    assign wd    = wd_reg;
    assign wreg  = wreg_reg;
    assign wdata = wdata_reg;
endmodule

// File: rtl/wb_regfile.sv
// General-purpose register file fed through the EX/MEM and MEM/WB result latches,
// with two combinational read ports. Define REGFILE_BYPASS_EN to forward in-flight results.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NREG   = RF_NREG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic [ADDR_W-1:0] ex_wd_i,
    input  logic              ex_wreg_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o,
    output logic [ADDR_W-1:0] wb_wd_o,
    output logic              wb_wreg_o,
    output logic [DATA_W-1:0] wb_wdata_o
);
    logic [ADDR_W-1:0] mem_wd;
    logic              mem_wreg;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] regs_reg [NREG];

    result_latch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ex_mem (
        .clk        (clk),
        .rst        (rst),
        .stall_self (stall[STALL_EX]),
        .stall_next (stall[STALL_MEM]),
        .src_wd     (ex_wd_i),
        .src_wreg   (ex_wreg_i),
        .src_wdata  (ex_wdata_i),
        .wd         (mem_wd),
        .wreg       (mem_wreg),
        .wdata      (mem_wdata)
    );

    result_latch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_wb (
        .clk        (clk),
        .rst        (rst),
        .stall_self (stall[STALL_MEM]),
        .stall_next (stall[STALL_WB]),
        .src_wd     (mem_wd),
        .src_wreg   (mem_wreg),
        .src_wdata  (mem_wdata),
        .wd         (wb_wd_o),
        .wreg       (wb_wreg_o),
        .wdata      (wb_wdata_o)
    );

    // r0 is never written so it reads as zero even if the array is inspected directly.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wb_wreg_o == WriteEnable && wb_wd_o != '0) begin
            regs_reg[wb_wd_o] <= wb_wdata_o;
        end
    end

    logic              re    [2];
    logic [ADDR_W-1:0] raddr [2];
    logic [DATA_W-1:0] rdata [2];

    assign re[0]    = re1_i;
    assign re[1]    = re2_i;
    assign raddr[0] = raddr1_i;
    assign raddr[1] = raddr2_i;
    assign rdata1_o = rdata[0];
    assign rdata2_o = rdata[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_read
            // Youngest producer first: EX, then EX/MEM, then MEM/WB, then the array.
            always_comb begin
                rdata[gi] = '0;
                if (rst == RstEnable || re[gi] != ReadEnable || raddr[gi] == '0) begin
                    rdata[gi] = '0;
`ifdef REGFILE_BYPASS_EN
                end else if (ex_wreg_i == WriteEnable && ex_wd_i == raddr[gi]) begin
                    rdata[gi] = ex_wdata_i;
                end else if (mem_wreg == WriteEnable && mem_wd == raddr[gi]) begin
                    rdata[gi] = mem_wdata;
                end else if (wb_wreg_o == WriteEnable && wb_wd_o == raddr[gi]) begin
                    rdata[gi] = wb_wdata_o;
`endif
                end else begin
                    rdata[gi] = regs_reg[raddr[gi]];
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios then randomized traffic,
// all compared each cycle against a register-file model kept in the bench.
module tb_wb_regfile;
    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;

    wb_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .ex_wd_i    (ex_wd),
        .ex_wreg_i  (ex_wreg),
        .ex_wdata_i (ex_wdata),
        .re1_i      (re1),
        .raddr1_i   (raddr1),
        .re2_i      (re2),
        .raddr2_i   (raddr2),
        .rdata1_o   (rdata1),
        .rdata2_o   (rdata2),
        .wb_wd_o    (wb_wd),
        .wb_wreg_o  (wb_wreg),
        .wb_wdata_o (wb_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
    } res_t;

    res_t        m_mem, m_wb;
    logic [31:0] m_regs [32];
    bit          model_valid = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Reference read: the newest in-flight result for the address wins, else the array.
    function automatic logic [31:0] model_read(input logic r_en, input logic [4:0] a);
        if (rst || !r_en || a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (ex_wreg && ex_wd == a) return ex_wdata;
        if (m_mem.wreg && m_mem.wd == a) return m_mem.wdata;
        if (m_wb.wreg && m_wb.wd == a) return m_wb.wdata;
`endif
        return m_regs[a];
    endfunction

    task automatic apply(input logic r, input logic [5:0] st, input logic [4:0] wd,
                         input logic wr, input logic [31:0] wdat,
                         input logic e1, input logic [4:0] a1,
                         input logic e2, input logic [4:0] a2);
        @(negedge clk);
        rst = r; stall = st; ex_wd = wd; ex_wreg = wr; ex_wdata = wdat;
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
        #1;
        $display("cyc %0d rst=%b stall=%b ex=%0d/%b/%h rd1[%0d]=%h rd2[%0d]=%h wb=%0d/%b/%h",
                 cyc, rst, stall, ex_wd, ex_wreg, ex_wdata, raddr1, rdata1, raddr2, rdata2,
                 wb_wd, wb_wreg, wb_wdata);
        check("rdata1", rdata1, model_read(re1, raddr1));
        check("rdata2", rdata2, model_read(re2, raddr2));
        if (model_valid) begin
            check("wb_wd", 32'(wb_wd), 32'(m_wb.wd));
            check("wb_wreg", 32'(wb_wreg), 32'(m_wb.wreg));
            check("wb_wdata", wb_wdata, m_wb.wdata);
        end
    endtask

    // Advance one edge and apply the latch and write rules to the model.
    task automatic step();
        res_t nm, nw;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_mem = '{wd: 0, wreg: 0, wdata: 0};
            m_wb  = '{wd: 0, wreg: 0, wdata: 0};
            for (int i = 0; i < 32; i++) m_regs[i] = 0;
            model_valid = 1;
            return;
        end
        if (m_wb.wreg && m_wb.wd != 0) m_regs[m_wb.wd] = m_wb.wdata;
        if (stall[3] && !stall[4])  nm = '{wd: 0, wreg: 0, wdata: 0};
        else if (!stall[3])         nm = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata};
        else                        nm = m_mem;
        if (stall[4] && !stall[5])  nw = '{wd: 0, wreg: 0, wdata: 0};
        else if (!stall[4])         nw = m_mem;
        else                        nw = m_wb;
        m_mem = nm;
        m_wb  = nw;
    endtask

    task automatic idle(input int n, input logic [4:0] a1);
        for (int i = 0; i < n; i++) begin
            apply(0, 6'b0, 5'd0, 0, 32'h0, 1, a1, 1, a1);
            step();
        end
    endtask

    initial begin
        rst = 1; stall = 0; ex_wd = 0; ex_wreg = 0; ex_wdata = 0;
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
        m_mem = '{wd: 0, wreg: 0, wdata: 0};
        m_wb  = '{wd: 0, wreg: 0, wdata: 0};
        for (int i = 0; i < 32; i++) m_regs[i] = 0;

        for (int i = 0; i < 2; i++) begin
            apply(1, 6'b0, 5'd0, 0, 32'h0, 1, 5'd1, 1, 5'd2);
            step();
        end

        // Reset after a completed write clears r5 and the latches.
        apply(0, 6'b0, 5'd5, 1, 32'h1234, 1, 5'd5, 0, 5'd0);
        step();
        idle(3, 5'd5);
        check("r5_before_reset", rdata1, 32'h1234);
        apply(1, 6'b0, 5'd0, 0, 32'h0, 1, 5'd5, 1, 5'd5);
        step();
        apply(0, 6'b0, 5'd0, 0, 32'h0, 1, 5'd5, 1, 5'd5);
        check("r5_after_reset", rdata1, 32'h0);
        check("wb_wreg_after_reset", 32'(wb_wreg), 32'h0);
        step();

        // Basic write then read through the pipeline.
        apply(0, 6'b0, 5'd3, 1, 32'hDEADBEEF, 1, 5'd3, 1, 5'd3);
`ifdef REGFILE_BYPASS_EN
        check("basic_c0", rdata1, 32'hDEADBEEF);
`else
        check("basic_c0", rdata1, 32'h0);
`endif
        step();
        idle(2, 5'd3);
        apply(0, 6'b0, 5'd0, 0, 32'h0, 1, 5'd3, 1, 5'd3);
        check("basic_c3", rdata1, 32'hDEADBEEF);
        step();

        // Three producers of r7 in flight; the youngest wins.
        for (int i = 1; i <= 3; i++) begin
            apply(0, 6'b0, 5'd7, 1, 32'(i), 1, 5'd7, 1, 5'd7);
`ifdef REGFILE_BYPASS_EN
            if (i == 3) check("prio_c2", rdata2, 32'h3);
`endif
            step();
        end
        idle(4, 5'd7);
        apply(0, 6'b0, 5'd0, 0, 32'h0, 1, 5'd7, 1, 5'd7);
        check("prio_final", rdata1, 32'h3);
        step();

        // r0 stays zero; a disabled port reads zero.
        for (int i = 0; i < 4; i++) begin
            apply(0, 6'b0, 5'd0, 1, 32'hFFFFFFFF, 1, 5'd0, 0, 5'd7);
            check("r0_read", rdata1, 32'h0);
            check("re2_off", rdata2, 32'h0);
            step();
        end

        // EX stalled with MEM running: bubbles, then capture on release.
        for (int i = 0; i < 2; i++) begin
            apply(0, 6'b001111, 5'd9, 1, 32'hAA, 1, 5'd9, 0, 5'd0);
            step();
        end
        idle(3, 5'd9);
        apply(0, 6'b0, 5'd0, 0, 32'h0, 1, 5'd9, 1, 5'd9);
        check("stall_no_write", rdata1, 32'h0);
        step();
        apply(0, 6'b0, 5'd9, 1, 32'hAA, 1, 5'd9, 1, 5'd9);
        step();
        idle(2, 5'd9);
        apply(0, 6'b0, 5'd0, 0, 32'h0, 1, 5'd9, 1, 5'd9);
        check("stall_release_write", rdata1, 32'hAA);
        step();

        // Reset while r4 sits in EX/MEM discards it.
        apply(0, 6'b0, 5'd4, 1, 32'h55, 1, 5'd4, 0, 5'd0);
        step();
        apply(1, 6'b0, 5'd0, 0, 32'h0, 1, 5'd4, 1, 5'd4);
        step();
        idle(3, 5'd4);
        apply(0, 6'b0, 5'd0, 0, 32'h0, 1, 5'd4, 1, 5'd4);
        check("midflight_r4", rdata1, 32'h0);
        check("midflight_wb_wreg", 32'(wb_wreg), 32'h0);
        step();

        // Randomized traffic on a small address range to force hazards.
        for (int i = 0; i < 1500; i++) begin
            logic        r;
            logic [5:0]  st;
            r  = ($urandom_range(0, 99) == 0);
            st = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
            apply(r, st, 5'($urandom_range(0, 7)), 1'($urandom), $urandom,
                  ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
